gray_seq_ctrl: RTL

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

---
 rtl/gray_seq_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/gray_seq_ctrl.sv
// Gray-code step sequencer: runs a commanded number of up/down steps on a binary
// counter and presents its Gray code. Optional wrap pulse output under GRAY_SEQ_WRAP_FLAG_EN.
module gray_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_dir,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_load_val,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] gray_out,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             done
`ifdef GRAY_SEQ_WRAP_FLAG_EN
    ,
    output logic             wrap
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_step;
    logic             dir;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign cmd_ready  = (state == IDLE);
    assign count_step = dir ? (count - WIDTH'(1)) : (count + WIDTH'(1));

    // gray_out is updated in the same assignment as count so they never disagree
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            gray_out  <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dir       <= 1'b0;
`ifdef GRAY_SEQ_WRAP_FLAG_EN
            wrap      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef GRAY_SEQ_WRAP_FLAG_EN
            wrap <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dir       <= cmd_dir;
                        remaining <= cmd_count;
                        if (cmd_load) begin
                            count    <= cmd_load_val;
                            gray_out <= to_gray(cmd_load_val);
                        end
                        if (cmd_count != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else if (!hold) begin
                        count     <= count_step;
                        gray_out  <= to_gray(count_step);
                        remaining <= remaining - CNT_W'(1);
`ifdef GRAY_SEQ_WRAP_FLAG_EN
                        wrap      <= dir ? (count == '0) : (count == '1);
`endif
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
